// File: rtl/ascon_perm_if.sv
// Request/response bundle between the Ascon mode FSM and the permutation sequencer.
// master = requester/consumer side, slave = permutation controller.
interface ascon_perm_if;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_rounds;
  logic [319:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] out_state;

  modport master (
    output in_valid, in_rounds, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_rounds, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Iterative Ascon permutation: one round per clock on a 320-bit state register,
// running rounds 12-N..11 for an N-round request (p^a / p^b).
module ascon_perm_ctrl #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  ascon_perm_if.slave     bus,
  input  logic            abort,
  output logic            busy,
  output logic [7:0]      cur_const
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  fsm_t         fsm_reg;
  logic [319:0] state_reg;
  logic [3:0]   rnd_idx_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         busy_reg;

  logic [3:0]   req_rounds;
  logic [0:4][63:0] x_w;
  logic [0:4][63:0] sbox_w;
  logic [0:4][63:0] lin_w;
  logic [63:0]  a0, a1, a2, a3, a4;
  logic [63:0]  t0, t1, t2, t3, t4;
  logic [63:0]  b0, b1, b2, b3, b4;

  assign req_rounds = (bus.in_rounds > MAX_R) ? MAX_R : bus.in_rounds;
  assign cur_const  = (fsm_reg == RUN) ? {4'hF - rnd_idx_reg, rnd_idx_reg} : 8'h00;

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_state = state_reg;
  assign busy          = busy_reg;

  // Word 0 is x0 in the top 64 bits.
  assign x_w = state_reg;

  // Constant addition and bitsliced 5-bit S-box across all 64 columns.
  always_comb begin
    a0 = x_w[0] ^ x_w[4];
    a1 = x_w[1];
    a2 = x_w[2] ^ {56'h0, cur_const} ^ x_w[1];
    a3 = x_w[3];
    a4 = x_w[4] ^ x_w[3];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;
    sbox_w[0] = b0 ^ b4;
    sbox_w[1] = b1 ^ b0;
    sbox_w[2] = ~b2;
    sbox_w[3] = b3 ^ b2;
    sbox_w[4] = b4;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_lin
      localparam int RA = ROT_A[gi];
      localparam int RB = ROT_B[gi];
      assign lin_w[gi] = sbox_w[gi]
                       ^ ((sbox_w[gi] >> RA) | (sbox_w[gi] << (64 - RA)))
                       ^ ((sbox_w[gi] >> RB) | (sbox_w[gi] << (64 - RB)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      rnd_idx_reg   <= 4'd0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg    <= bus.in_state;
            rnd_idx_reg  <= 4'd12 - req_rounds;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            if (req_rounds == 4'd0) begin
              fsm_reg       <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              fsm_reg <= RUN;
            end
          end
        end
        RUN: begin
          // Aborted runs keep the partially permuted state visible.
          if (abort) begin
            fsm_reg      <= IDLE;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end else begin
            state_reg   <= lin_w;
            rnd_idx_reg <= rnd_idx_reg + 4'd1;
            if (rnd_idx_reg == 4'd11) begin
              fsm_reg       <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort || bus.out_ready) begin
            fsm_reg       <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          fsm_reg       <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Randomized bench for ascon_perm_ctrl against a table-driven Ascon round model.
module tb_ascon_perm_ctrl;

  logic       clk;
  logic       rst_n;
  logic       abort;
  logic       busy;
  logic [7:0] cur_const;
  int         n_vec;
  int         n_err;

  ascon_perm_if bus ();

  ascon_perm_ctrl #(.MAX_ROUNDS(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .abort     (abort),
    .busy      (busy),
    .cur_const (cur_const)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror64(logic [63:0] v, int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [7:0] round_const(int i);
    return 8'(((15 - i) << 4) | i);
  endfunction

  function automatic logic [319:0] model_round(logic [319:0] s, logic [7:0] c);
    logic [63:0]  x [5];
    logic [63:0]  y [5];
    logic [4:0]   col;
    logic [4:0]   sv;
    logic [319:0] r;
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    x[2] = x[2] ^ {56'h0, c};
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      sv  = SBOX[col];
      y[0][b] = sv[4];
      y[1][b] = sv[3];
      y[2][b] = sv[2];
      y[3][b] = sv[1];
      y[4][b] = sv[0];
    end
    for (int w = 0; w < 5; w++)
      r[319 - 64*w -: 64] = y[w] ^ ror64(y[w], RA[w]) ^ ror64(y[w], RB[w]);
    return r;
  endfunction

  function automatic logic [319:0] model_rounds(logic [319:0] s, int first, int cnt);
    logic [319:0] v;
    v = s;
    for (int i = first; i < first + cnt; i++) v = model_round(v, round_const(i));
    return v;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  320'(bus.in_ready),  320'd1);
    chk({tag, "_out_valid"}, 320'(bus.out_valid), 320'd0);
    chk({tag, "_busy"},      320'(busy),          320'd0);
    chk({tag, "_cur_const"}, 320'(cur_const),     320'd0);
    chk({tag, "_out_state"}, bus.out_state,       320'd0);
  endtask

  // Full transaction: issue, watch the round constants, hold the result bp cycles, hand off.
  task automatic run_perm(input logic [3:0] r, input logic [319:0] st, input int bp,
                          input logic idle_abort);
    int           n;
    int           waitc;
    logic [319:0] exp;
    n   = (r > 4'd12) ? 12 : int'(r);
    exp = model_rounds(st, 12 - n, n);
    waitc = 0;
    while (!bus.in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_ready", 320'(bus.in_ready), 320'd1);
    bus.in_valid  = 1'b1;
    bus.in_rounds = r;
    bus.in_state  = st;
    abort         = idle_abort;
    @(negedge clk);
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rounds = 4'($urandom);
    bus.in_state  = rand320();
    for (int k = 0; k < n; k++) begin
      chk("run_const", 320'(cur_const), 320'(round_const(12 - n + k)));
      chk("run_out_valid", 320'(bus.out_valid), 320'd0);
      chk("run_busy", 320'(busy), 320'd1);
      @(negedge clk);
    end
    chk("done_out_valid", 320'(bus.out_valid), 320'd1);
    chk("done_state", bus.out_state, exp);
    chk("done_const", 320'(cur_const), 320'd0);
    chk("done_in_ready", 320'(bus.in_ready), 320'd0);
    for (int b = 0; b < bp; b++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", 320'(bus.out_valid), 320'd1);
      chk("bp_state", bus.out_state, exp);
      chk("bp_in_ready", 320'(bus.in_ready), 320'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("handoff_out_valid", 320'(bus.out_valid), 320'd0);
    chk("handoff_in_ready", 320'(bus.in_ready), 320'd1);
    chk("handoff_busy", 320'(busy), 320'd0);
    chk("handoff_state_kept", bus.out_state, exp);
    $display("perm rounds=%0d bp=%0d idle_abort=%0d result=%0h", r, bp, idle_abort, bus.out_state);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [319:0] st;
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rounds = 4'd0;
    bus.in_state  = '0;
    bus.out_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_perm(4'd12, 320'd0, 0, 1'b0);
    run_perm(4'd6,  rand320(), 0, 1'b0);
    run_perm(4'd0,  rand320(), 0, 1'b0);
    run_perm(4'd15, rand320(), 0, 1'b0);
    run_perm(4'd8,  rand320(), 5, 1'b0);
    run_perm(4'd6,  rand320(), 0, 1'b1);

    // Abort during the third RUN cycle of a p8.
    st = rand320();
    bus.in_valid  = 1'b1;
    bus.in_rounds = 4'd8;
    bus.in_state  = st;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_out_valid", 320'(bus.out_valid), 320'd0);
    chk("abort_in_ready", 320'(bus.in_ready), 320'd1);
    chk("abort_busy", 320'(busy), 320'd0);
    chk("abort_partial", bus.out_state, model_rounds(st, 4, 2));
    @(negedge clk);
    chk("abort_no_valid", 320'(bus.out_valid), 320'd0);
    $display("abort p8 after 2 rounds partial=%0h", bus.out_state);
    run_perm(4'd8, rand320(), 0, 1'b0);

    // Asynchronous reset in the middle of a p12.
    bus.in_valid  = 1'b1;
    bus.in_rounds = 4'd12;
    bus.in_state  = rand320();
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    $display("async reset mid-run applied");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_perm(4'd12, rand320(), 0, 1'b0);

    for (int t = 0; t < 20; t++)
      run_perm(4'($urandom_range(0, 15)), rand320(), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
